// File: rtl/hex_digit_scanner_if.sv
// Load handshake and scanned-digit outputs shared between a scanner and its host.
interface hex_digit_scanner_if #(
  parameter int NDIGITS = 4
);
  logic                   load;
  logic [4*NDIGITS-1:0]   data;
  logic                   ready;
  logic                   in1;
  logic                   in2;
  logic                   in3;
  logic                   in4;
  logic [NDIGITS-1:0]     digit_sel;
  logic                   blank;

  modport master (
    output load, data,
    input  ready, in1, in2, in3, in4, digit_sel, blank
  );

  modport slave (
    input  load, data,
    output ready, in1, in2, in3, in4, digit_sel, blank
  );
endinterface

// File: rtl/hex_digit_scanner.sv
// Time-multiplexed hex display scanner; new values commit only at frame wrap.
// Optional leading-zero blanking is enabled by defining HEX_SCAN_LZB_EN.
module hex_digit_scanner #(
  parameter int NDIGITS  = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  hex_digit_scanner_if.slave    bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(NDIGITS);
  localparam int DW = 4 * NDIGITS;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIGITS - 1);

  logic [PW-1:0]      pcnt, pcnt_nxt;
  logic [IW-1:0]      idx, idx_nxt;
  logic [DW-1:0]      shadow, shadow_nxt;
  logic [DW-1:0]      disp, disp_nxt;
  logic               pend, pend_nxt;
  logic [3:0]         nib_q, nib_nxt;
  logic [NDIGITS-1:0] sel_q, sel_nxt;
  logic               blank_q, blank_nxt;
  logic               tick, wrap, accept;

  always_comb begin
    tick       = (pcnt == PCNT_LAST);
    wrap       = tick && (idx == IDX_LAST);
    accept     = bus.load && !pend;
    pcnt_nxt   = tick ? '0 : pcnt + PW'(1);
    idx_nxt    = idx;
    disp_nxt   = disp;
    shadow_nxt = shadow;
    pend_nxt   = pend;
    if (tick) idx_nxt = wrap ? '0 : idx + IW'(1);
    // accept needs !pend, so it can never coincide with a commit
    if (wrap && pend) begin
      disp_nxt = shadow;
      pend_nxt = 1'b0;
    end else if (accept) begin
      shadow_nxt = bus.data;
      pend_nxt   = 1'b1;
    end
    nib_nxt = disp_nxt[{idx_nxt, 2'b00} +: 4];
    sel_nxt = NDIGITS'(1) << idx_nxt;
  end

`ifdef HEX_SCAN_LZB_EN
  logic [NDIGITS-1:0] lz;
  logic               zero_run;

  // A digit is dark when it and every more-significant nibble are zero; digit 0 always lit.
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (disp_nxt[4*i +: 4] == 4'h0);
      lz[i]    = zero_run;
    end
    blank_nxt = lz[idx_nxt];
  end
`else
  assign blank_nxt = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt    <= '0;
      idx     <= '0;
      shadow  <= '0;
      disp    <= '0;
      pend    <= 1'b0;
      nib_q   <= 4'h0;
      sel_q   <= NDIGITS'(1);
      blank_q <= 1'b0;
    end else begin
      pcnt    <= pcnt_nxt;
      idx     <= idx_nxt;
      shadow  <= shadow_nxt;
      disp    <= disp_nxt;
      pend    <= pend_nxt;
      nib_q   <= nib_nxt;
      sel_q   <= sel_nxt;
      blank_q <= blank_nxt;
    end
  end

  assign bus.ready     = !pend;
  assign bus.in1       = nib_q[3];
  assign bus.in2       = nib_q[2];
  assign bus.in3       = nib_q[1];
  assign bus.in4       = nib_q[0];
  assign bus.digit_sel = sel_q;
  assign bus.blank     = blank_q;
endmodule

// File: tb/tb_hex_digit_scanner.sv
// Directed bench for hex_digit_scanner with NDIGITS=4, PRESCALE=4.
module tb_hex_digit_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   s = 0;

  hex_digit_scanner_if #(.NDIGITS(4)) bus ();

  hex_digit_scanner #(.NDIGITS(4), .PRESCALE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    s++;
  endtask

  task automatic step_to(input int target);
    while (s < target) step();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    bus.load = 1'b0;
    bus.data = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    s = 0;
  endtask

  function automatic logic [3:0] nib();
    return {bus.in1, bus.in2, bus.in3, bus.in4};
  endfunction

  task automatic test_reset();
    do_reset();
    vectors++;
    if (bus.digit_sel !== 4'b0001 || nib() !== 4'h0 || bus.ready !== 1'b1 || bus.blank !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: sel=%b nib=%h ready=%b blank=%b, want 0001/0/1/0",
               bus.digit_sel, nib(), bus.ready, bus.blank);
    end
    bus.load = 1'b1;
    bus.data = 16'h5555;
    step();
    bus.load = 1'b0;
    step_to(8);
    vectors++;
    if (bus.digit_sel !== 4'b0100 || bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_reset_midframe: sel=%b ready=%b, want 0100/0", bus.digit_sel, bus.ready);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (bus.digit_sel !== 4'b0001 || nib() !== 4'h0 || bus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: sel=%b nib=%h ready=%b, want 0001/0/1",
               bus.digit_sel, nib(), bus.ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    s = 0;
    step_to(16);
    vectors++;
    if (nib() !== 4'h0 || bus.digit_sel !== 4'b0001) begin
      miscompares++;
      $display("FAIL pending_discarded: nib=%h sel=%b, want 0/0001", nib(), bus.digit_sel);
    end
  endtask

  task automatic test_scan_cadence();
    logic [3:0] exp_sel;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step_to(k);
      exp_sel = 4'b0001 << ((k / 4) % 4);
      vectors++;
      if (bus.digit_sel !== exp_sel || nib() !== 4'h0) begin
        miscompares++;
        $display("FAIL scan_cadence[%0d]: sel=%b nib=%h, want %b/0", k, bus.digit_sel, nib(), exp_sel);
      end
    end
  endtask

  task automatic test_load_commit();
    logic [3:0] exp_nib [4];
    exp_nib[0] = 4'h3; exp_nib[1] = 4'hF; exp_nib[2] = 4'h7; exp_nib[3] = 4'hA;
    do_reset();
    step_to(4);
    bus.load = 1'b1;
    bus.data = 16'hA7F3;
    step();
    bus.load = 1'b0;
    for (int k = 5; k < 16; k++) begin
      step_to(k);
      vectors++;
      if (bus.ready !== 1'b0 || nib() !== 4'h0) begin
        miscompares++;
        $display("FAIL ready_low[%0d]: ready=%b nib=%h, want 0/0", k, bus.ready, nib());
      end
    end
    for (int d = 0; d < 4; d++) begin
      step_to(16 + 4 * d);
      vectors++;
      if (nib() !== exp_nib[d] || bus.digit_sel !== (4'b0001 << d) || bus.ready !== 1'b1) begin
        miscompares++;
        $display("FAIL commit_digit%0d: nib=%h sel=%b ready=%b, want %h/%b/1",
                 d, nib(), bus.digit_sel, bus.ready, exp_nib[d], 4'b0001 << d);
      end
    end
  endtask

  task automatic test_load_while_pending();
    do_reset();
    bus.load = 1'b1;
    bus.data = 16'h1111;
    step();
    bus.load = 1'b0;
    step_to(2);
    bus.load = 1'b1;
    bus.data = 16'h1234;
    step();
    bus.load = 1'b0;
    for (int d = 0; d < 4; d++) begin
      step_to(16 + 4 * d);
      vectors++;
      if (nib() !== 4'h1) begin
        miscompares++;
        $display("FAIL ignored_load_digit%0d: nib=%h, want 1", d, nib());
      end
    end
    step_to(36);
    vectors++;
    if (nib() !== 4'h1 || bus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL not_queued: nib=%h ready=%b, want 1/1", nib(), bus.ready);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step_to(14);
    bus.load = 1'b1;
    bus.data = 16'hBEEF;
    step();
    bus.load = 1'b0;
    vectors++;
    if (nib() !== 4'h0 || bus.digit_sel !== 4'b1000 || bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL boundary_pre: nib=%h sel=%b ready=%b, want 0/1000/0", nib(), bus.digit_sel, bus.ready);
    end
    step();
    vectors++;
    if (nib() !== 4'hF || bus.digit_sel !== 4'b0001 || bus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL boundary_latency: nib=%h sel=%b ready=%b, want F/0001/1", nib(), bus.digit_sel, bus.ready);
    end
    bus.load = 1'b1;
    bus.data = 16'h0C00;
    step();
    bus.load = 1'b0;
    step_to(20);
    vectors++;
    if (nib() !== 4'hE) begin
      miscompares++;
      $display("FAIL old_frame_kept: nib=%h, want E", nib());
    end
    step_to(40);
    vectors++;
    if (nib() !== 4'hC || bus.digit_sel !== 4'b0100) begin
      miscompares++;
      $display("FAIL back_to_back: nib=%h sel=%b, want C/0100", nib(), bus.digit_sel);
    end
  endtask

  task automatic test_blank();
    logic [3:0] pat_b0, pat_zero;
`ifdef HEX_SCAN_LZB_EN
    pat_b0   = 4'b1100;
    pat_zero = 4'b1110;
`else
    pat_b0   = 4'b0000;
    pat_zero = 4'b0000;
`endif
    do_reset();
    bus.load = 1'b1;
    bus.data = 16'h00B0;
    step();
    bus.load = 1'b0;
    for (int d = 0; d < 4; d++) begin
      step_to(16 + 4 * d);
      vectors++;
      if (bus.blank !== pat_b0[d]) begin
        miscompares++;
        $display("FAIL blank_00B0_digit%0d: blank=%b, want %b", d, bus.blank, pat_b0[d]);
      end
    end
    bus.load = 1'b1;
    bus.data = 16'h0000;
    step();
    bus.load = 1'b0;
    for (int d = 0; d < 4; d++) begin
      step_to(32 + 4 * d);
      vectors++;
      if (bus.blank !== pat_zero[d] || nib() !== 4'h0) begin
        miscompares++;
        $display("FAIL blank_0000_digit%0d: blank=%b nib=%h, want %b/0", d, bus.blank, nib(), pat_zero[d]);
      end
    end
  endtask

  initial begin
    bus.load = 1'b0;
    bus.data = '0;
    test_reset();
    test_scan_cadence();
    test_load_commit();
    test_load_while_pending();
    test_back_to_back();
    test_blank();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
